// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use, redirect and fetch-miss hazard control for the 5-stage core.
// Define HAZARD_PERF_EN to build the saturating stall/flush perf counters.
module hazard_ctrl #(
    parameter int LOAD_LAT = 1,
    parameter int TIMEOUT  = 64,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       IF_ID_Rs,
    input  logic [4:0]       IF_ID_Rt,
    input  logic             IF_ID_UsesRt,
    input  logic             ID_EX_MemRead,
    input  logic [4:0]       ID_EX_Rt,
    input  logic             Branch_Taken,
    input  logic             Jump,
    input  logic             IMem_Ready,
    output logic             PC_Write,
    output logic             IF_ID_Write,
    output logic             Flush,
    output logic             ID_EX_Bubble,
    output logic             Timeout_Err,
    output logic [CNT_W-1:0] Stall_Count,
    output logic [CNT_W-1:0] Flush_Count
);
    typedef enum logic [1:0] {RUN, LU_STALL, IMISS} state_t;
    state_t     state, state_n;
    logic [3:0] cnt, cnt_n;
    logic [7:0] timer, timer_n;
    logic       err_n, hazard, pc_w, ifid_w, flush, bubble;
    assign hazard = ID_EX_MemRead && (ID_EX_Rt != 5'd0) &&
                    ((ID_EX_Rt == IF_ID_Rs) || (IF_ID_UsesRt && (ID_EX_Rt == IF_ID_Rt)));
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        timer_n = timer;
        err_n   = Timeout_Err;
        pc_w    = 1'b0;
        ifid_w  = 1'b0;
        flush   = 1'b0;
        bubble  = 1'b0;
        case (state)
            RUN: begin
                if (hazard) begin
                    bubble = 1'b1;
                    if (LOAD_LAT > 1) begin
                        state_n = LU_STALL;
                        cnt_n   = 4'(LOAD_LAT - 1);
                    end
                end else if (Branch_Taken || Jump) begin
                    pc_w   = 1'b1;
                    ifid_w = 1'b1;
                    flush  = 1'b1;
                end else if (!IMem_Ready) begin
                    flush   = 1'b1;
                    state_n = IMISS;
                    timer_n = 8'd1;
                end else begin
                    pc_w   = 1'b1;
                    ifid_w = 1'b1;
                end
            end
            LU_STALL: begin
                bubble = 1'b1;
                cnt_n  = cnt - 4'd1;
                if (cnt <= 4'd1) state_n = RUN;
            end
            IMISS: begin
                if (!IMem_Ready) begin
                    flush   = 1'b1;
                    timer_n = (timer == 8'hFF) ? timer : timer + 8'd1;
                    if (timer_n == 8'(TIMEOUT)) err_n = 1'b1;
                end else begin
                    pc_w    = 1'b1;
                    ifid_w  = 1'b1;
                    state_n = RUN;
                end
            end
            default: state_n = RUN;
        endcase
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= RUN;
            cnt         <= '0;
            timer       <= '0;
            Timeout_Err <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            timer       <= timer_n;
            Timeout_Err <= err_n;
        end
    end
    // Reset forces every pipeline control low, whatever the state decode says.
    assign PC_Write     = rst & pc_w;
    assign IF_ID_Write  = rst & ifid_w;
    assign Flush        = rst & flush;
    assign ID_EX_Bubble = rst & bubble;
`ifdef HAZARD_PERF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            Stall_Count <= '0;
            Flush_Count <= '0;
        end else begin
            if (!pc_w && !(&Stall_Count)) Stall_Count <= Stall_Count + CNT_W'(1);
            if (flush && !(&Flush_Count)) Flush_Count <= Flush_Count + CNT_W'(1);
        end
    end
`else
    assign Stall_Count = '0;
    assign Flush_Count = '0;
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: two hazard_ctrl builds (LOAD_LAT 3 and 1) driven in lockstep, scored
// against a cycle-level reference model through per-instance expectation queues.
module tb_hazard_ctrl;
`ifdef HAZARD_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif
    localparam int LAT [2] = '{3, 1};
    localparam int TMO [2] = '{3, 5};
    localparam int CW  [2] = '{32, 4};

    typedef struct {
        logic [4:0] ctl;
        longint     sc;
        longint     fc;
    } exp_t;

    logic clk = 1'b0, rst = 1'b0;
    logic [4:0] rs = '0, rt = '0, ert = '0;
    logic ur = 1'b0, mr = 1'b0, bt = 1'b0, jp = 1'b0, rdy = 1'b1;
    logic a_pc, a_iw, a_fl, a_bb, a_err, b_pc, b_iw, b_fl, b_bb, b_err;
    logic [31:0] a_sc, a_fc;
    logic [3:0]  b_sc, b_fc;
    int checks = 0, fails = 0;
    exp_t qa[$], qb[$];
    exp_t ea, eb;
    int     stall_left [2];
    int     miss_run   [2];
    bit     err        [2];
    longint sc         [2];
    longint fc         [2];

    always #5 clk = ~clk;

    hazard_ctrl #(.LOAD_LAT(3), .TIMEOUT(3), .CNT_W(32)) ua (
        .clk(clk), .rst(rst), .IF_ID_Rs(rs), .IF_ID_Rt(rt), .IF_ID_UsesRt(ur),
        .ID_EX_MemRead(mr), .ID_EX_Rt(ert), .Branch_Taken(bt), .Jump(jp), .IMem_Ready(rdy),
        .PC_Write(a_pc), .IF_ID_Write(a_iw), .Flush(a_fl), .ID_EX_Bubble(a_bb),
        .Timeout_Err(a_err), .Stall_Count(a_sc), .Flush_Count(a_fc));

    hazard_ctrl #(.LOAD_LAT(1), .TIMEOUT(5), .CNT_W(4)) ub (
        .clk(clk), .rst(rst), .IF_ID_Rs(rs), .IF_ID_Rt(rt), .IF_ID_UsesRt(ur),
        .ID_EX_MemRead(mr), .ID_EX_Rt(ert), .Branch_Taken(bt), .Jump(jp), .IMem_Ready(rdy),
        .PC_Write(b_pc), .IF_ID_Write(b_iw), .Flush(b_fl), .ID_EX_Bubble(b_bb),
        .Timeout_Err(b_err), .Stall_Count(b_sc), .Flush_Count(b_fc));

    function automatic longint sat_inc(input longint v, input int w);
        longint mx = (longint'(1) << w) - 1;
        return (v >= mx) ? mx : v + 1;
    endfunction

    // One cycle of the reference: stall phase, then pending fetch, then RUN priorities.
    task automatic model(input int k, input bit r);
        exp_t e;
        bit hz = mr && (ert != 5'd0) && ((ert == rs) || (ur && (ert == rt)));
        bit pc = 0, iw = 0, fl = 0, bb = 0;
        if (!r) begin
            stall_left[k] = 0; miss_run[k] = 0; err[k] = 0; sc[k] = 0; fc[k] = 0;
        end
        e.sc = PERF ? sc[k] : 0;
        e.fc = PERF ? fc[k] : 0;
        e.ctl[0] = err[k];
        if (!r) begin
        end else if (stall_left[k] > 0) begin
            bb = 1; stall_left[k]--;
        end else if (miss_run[k] > 0) begin
            if (!rdy) begin
                fl = 1; miss_run[k]++;
                if (miss_run[k] == TMO[k]) err[k] = 1;
            end else begin
                pc = 1; iw = 1; miss_run[k] = 0;
            end
        end else if (hz) begin
            bb = 1; stall_left[k] = LAT[k] - 1;
        end else if (bt || jp) begin
            pc = 1; iw = 1; fl = 1;
        end else if (!rdy) begin
            fl = 1; miss_run[k] = 1;
        end else begin
            pc = 1; iw = 1;
        end
        e.ctl[4:1] = {pc, iw, fl, bb};
        if (r && !pc) sc[k] = sat_inc(sc[k], CW[k]);
        if (r && fl)  fc[k] = sat_inc(fc[k], CW[k]);
        if (k == 0) qa.push_back(e); else qb.push_back(e);
    endtask

    task automatic cyc(input bit r, input bit m, input logic [4:0] e, input logic [4:0] s,
                       input logic [4:0] t, input bit u, input bit b, input bit j, input bit y);
        @(posedge clk);
        #1;
        rst = r; mr = m; ert = e; rs = s; rt = t; ur = u; bt = b; jp = j; rdy = y;
        model(0, r);
        model(1, r);
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1, 0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    // Reset pulse that starts and ends between clock edges.
    task automatic pulse();
        @(posedge clk);
        #1;
        rst = 0; mr = 0; ert = 0; rs = 0; rt = 0; ur = 0; bt = 0; jp = 0; rdy = 1;
        model(0, 0);
        model(1, 0);
        @(negedge clk);
        #1;
        rst = 1;
    endtask

    function automatic void cmp(input string n, input exp_t e, input logic [4:0] ctl,
                                input longint s, input longint f);
        checks += 3;
        if (ctl !== e.ctl) begin
            fails++;
            $display("FAIL %s ctl{pc,ifid,flush,bubble,err} got %b want %b @%0t", n, ctl, e.ctl, $time);
        end
        if (s != e.sc) begin
            fails++;
            $display("FAIL %s stall_count got %0d want %0d @%0t", n, s, e.sc, $time);
        end
        if (f != e.fc) begin
            fails++;
            $display("FAIL %s flush_count got %0d want %0d @%0t", n, f, e.fc, $time);
        end
    endfunction

    always @(negedge clk) begin
        if (qa.size() > 0) begin
            ea = qa.pop_front();
            cmp("A", ea, {a_pc, a_iw, a_fl, a_bb, a_err}, longint'(a_sc), longint'(a_fc));
        end
        if (qb.size() > 0) begin
            eb = qb.pop_front();
            cmp("B", eb, {b_pc, b_iw, b_fl, b_bb, b_err}, longint'(b_sc), longint'(b_fc));
        end
    end

    initial begin
        repeat (3) cyc(0, 0, 0, 0, 0, 0, 0, 0, 1);
        idle(2);
        cyc(1, 1, 5, 5, 0, 0, 1, 0, 1);
        repeat (4) cyc(1, 0, 0, 0, 0, 0, 1, 0, 1);
        cyc(1, 1, 0, 0, 0, 1, 0, 0, 1);
        cyc(1, 1, 7, 1, 7, 0, 0, 0, 1);
        cyc(1, 1, 7, 1, 7, 1, 0, 0, 1);
        idle(3);
        repeat (6) cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(2);
        cyc(1, 0, 0, 0, 0, 0, 0, 1, 1);
        cyc(1, 0, 0, 0, 0, 0, 1, 0, 0);
        idle(1);
        cyc(1, 1, 9, 2, 9, 1, 0, 0, 0);
        idle(3);
        cyc(1, 1, 4, 4, 0, 0, 0, 0, 1);
        pulse();
        idle(3);
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(99) == 0) pulse();
            else cyc(1, $urandom_range(99) < 40, 5'($urandom_range(3)), 5'($urandom_range(3)),
                     5'($urandom_range(3)), $urandom_range(1) == 1, $urandom_range(99) < 20,
                     $urandom_range(99) < 10, $urandom_range(99) < 70);
        end
        @(negedge clk);
        #1;
        checks++;
        if (qa.size() != 0 || qb.size() != 0) begin
            fails++;
            $display("FAIL drain queued got %0d want 0", qa.size() + qb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
